// File: rtl/free_list.sv
// free_list: circular FIFO of physical register tags for a rename stage.
// Tags are returned at the tail (wr) and handed out from the head (rd).
// The head is shown ahead, so the tag taken on an rd cycle is the one
// on data_out during that cycle. Reset preloads every tag that is not
// mapped to an architectural register.
//
// Ports:
//   clock    - single clock, all state updates on the rising edge
//   reset    - synchronous, active-high; overrides rd/wr
//   data_in  - tag returned to the list when wr=1
//   wr       - push data_in at the tail (dropped when full unless popping too)
//   rd       - pop the head entry (ignored when empty)
//   data_out - current head tag, all zeros when empty
//   empty    - list holds zero entries
module free_list #(
  parameter int unsigned CDB_BITS = 7,
  parameter int unsigned NUM_PHYS = 128,
  parameter int unsigned NUM_ARCH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CDB_BITS-1:0] data_in,
  input  logic                wr,
  input  logic                rd,
  output logic [CDB_BITS-1:0] data_out,
  output logic                empty
);

  localparam int unsigned PTR_W       = $clog2(NUM_PHYS);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned FREE_AT_RST = NUM_PHYS - NUM_ARCH;

  logic [CDB_BITS-1:0] mem_q [NUM_PHYS];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic pop_ok;
  logic push_ok;
  logic full;

  assign full  = (count_q == CNT_W'(NUM_PHYS));
  assign empty = (count_q == '0);

  // Show-ahead head tag; forced to zero so stale contents never leak out.
  assign data_out = empty ? '0 : mem_q[head_q];

  // A push on a full list is only accepted when a pop frees the slot in
  // the same cycle. A pop on an empty list never bypasses a same-cycle push.
  assign pop_ok  = rd && !empty;
  assign push_ok = wr && (!full || pop_ok);

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok) begin
      head_d = (head_q == PTR_W'(NUM_PHYS - 1)) ? '0 : head_q + PTR_W'(1);
    end
    if (push_ok) begin
      tail_d = (tail_q == PTR_W'(NUM_PHYS - 1)) ? '0 : tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // State registers; reset reloads the free tags NUM_ARCH..NUM_PHYS-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) begin
        mem_q[i] <= (i < FREE_AT_RST) ? CDB_BITS'(NUM_ARCH + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= PTR_W'(FREE_AT_RST);
      count_q <= CNT_W'(FREE_AT_RST);
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= data_in;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int unsigned CDB_BITS = 7;
  localparam int unsigned NUM_PHYS = 128;
  localparam int unsigned NUM_ARCH = 32;

  logic                clock;
  logic                reset;
  logic [CDB_BITS-1:0] data_in;
  logic                wr;
  logic                rd;
  logic [CDB_BITS-1:0] data_out;
  logic                empty;

  free_list #(
    .CDB_BITS(CDB_BITS),
    .NUM_PHYS(NUM_PHYS),
    .NUM_ARCH(NUM_ARCH)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .wr      (wr),
    .rd      (rd),
    .data_out(data_out),
    .empty   (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: the list as a plain queue of tags, head at index 0.
  logic [CDB_BITS-1:0] model_q[$];
  // Expected {empty, data_out} after each edge.
  logic [CDB_BITS:0]   exp_q[$];
  string               tag_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic void model_reset();
    model_q.delete();
    for (int i = NUM_ARCH; i < NUM_PHYS; i++) model_q.push_back(CDB_BITS'(i));
  endfunction

  // One clock: drive at negedge, apply the rules to the model at posedge,
  // and queue what the outputs must show afterwards.
  task automatic step(input logic rs, input logic r, input logic w,
                      input logic [CDB_BITS-1:0] d, input string name);
    logic pop_ok, push_ok;
    logic [CDB_BITS-1:0] head;
    @(negedge clock);
    reset = rs; rd = r; wr = w; data_in = d;
    @(posedge clock);
    if (rs) begin
      model_reset();
    end else begin
      pop_ok  = r && (model_q.size() > 0);
      push_ok = w && ((model_q.size() < NUM_PHYS) || pop_ok);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
    end
    head = (model_q.size() > 0) ? model_q[0] : '0;
    exp_q.push_back({model_q.size() == 0, head});
    tag_q.push_back(name);
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  always @(posedge clock) begin
    logic [CDB_BITS:0] e;
    string nm;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = tag_q.pop_front();
      checks++;
      if (data_out !== e[CDB_BITS-1:0] || empty !== e[CDB_BITS]) begin
        failures++;
        $display("FAIL %s cyc=%0d: data_out=%0d empty=%0b, expected data_out=%0d empty=%0b",
                 nm, cyc, data_out, empty, e[CDB_BITS-1:0], e[CDB_BITS]);
      end
    end
  end

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, name);
  endtask

  initial begin
    logic [CDB_BITS-1:0] d;
    int rd_pct, wr_pct;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; data_in = '0;
    model_reset();

    // Reset state, then pops 32..36 and pushes while popping is idle.
    step(1'b1, 1'b0, 1'b0, '0, "reset");
    idle(1, "post_reset");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0, "pop5");
    step(1'b0, 1'b0, 1'b1, 7'h12, "push5");
    for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 1'b1, CDB_BITS'(i), "push5");
    // Drain everything, then keep popping an empty list.
    for (int i = 0; i < 96; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0, "underflow");

    // From empty: push, push, rd+wr, push; then drain the 3 left.
    step(1'b0, 1'b0, 1'b1, 7'd5, "seq_push5");
    step(1'b0, 1'b0, 1'b1, 7'd6, "seq_push6");
    step(1'b0, 1'b1, 1'b1, 7'd7, "seq_rdwr7");
    step(1'b0, 1'b0, 1'b1, 7'd8, "seq_push8");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, "seq_drain");

    // rd+wr on empty performs only the push; repeated it keeps count at 1.
    step(1'b0, 1'b1, 1'b1, 7'd9, "empty_rdwr");
    step(1'b0, 1'b1, 1'b1, 7'd9, "one_rdwr");
    step(1'b0, 1'b1, 1'b0, '0, "one_pop");
    step(1'b0, 1'b1, 1'b0, '0, "one_pop_empty");

    // Fill with wrapped pointers, overflow attempts, rd+wr at full.
    step(1'b1, 1'b0, 1'b0, '0, "reset2");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0, "pre_pop");
    for (int i = 0; i < 42; i++)
      step(1'b0, 1'b0, 1'b1, CDB_BITS'($urandom_range(0, 127)), "fill");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 7'h7f, "overflow");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b1, CDB_BITS'($urandom_range(0, 127)), "full_rdwr");
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0, '0, "partial_drain");
    // Reset mid-operation overrides rd and wr.
    step(1'b1, 1'b1, 1'b1, 7'h55, "mid_reset");
    for (int i = 0; i < 97; i++) step(1'b0, 1'b1, 1'b0, '0, "drain_after_reset");

    // Randomized phases alternating fill and drain bias.
    for (int ph = 0; ph < 8; ph++) begin
      rd_pct = (ph % 2 == 0) ? 25 : 85;
      wr_pct = (ph % 2 == 0) ? 85 : 25;
      for (int i = 0; i < 300; i++) begin
        d = CDB_BITS'($urandom_range(0, 127));
        step(($urandom_range(0, 499) == 0),
             ($urandom_range(0, 99) < rd_pct),
             ($urandom_range(0, 99) < wr_pct), d, "random");
      end
    end

    idle(2, "final");
    @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
